lcd_scn_streamer: RTL
=====================

// Module: lcd_scn_streamer
// PURPOSE
//  Parametrised successor to the fixed single-screen drawer: streams one of NUM_SCN stored screens
//  from an external sync-read ROM to a PCD8544-class LCD over a built-in SPI engine.
//  Adds an optional config-byte preamble, a constant-fill (clear) mode and a power-up LCD reset pulse.
//  Exposes a start/busy/done handshake and a selection-range error.
//  Sits between the wishbone static-screen register slave and the pmod pins.
// PARAMETERS
//  NUM_SCN        16    number of stored screens
//  BYTES_PER_SCN  504   data bytes per screen (84x48/8)
//  CFG_BYTES      5     config bytes stored once at ROM addr 0..CFG_BYTES-1
//  ADDR_W         13    ROM address width; must hold CFG_BYTES+NUM_SCN*BYTES_PER_SCN-1
//  CLK_DIV        4     clk cycles per sck half-period (>=1)
//  RST_CYCLES     16    clk cycles lcd_rst_n held low after reset
// PORTS
//  clk        in   1       system clock
//  rst        in   1       asynchronous reset, active-low
//  start      in   1       1-cycle request; sampled only in IDLE
//  scn_sel    in   4       screen index, captured on accepted start
//  send_cfg   in   1       1: send CFG_BYTES preamble (dc=0) before screen data; captured on start
//  fill_en    in   1       1: send fill_byte BYTES_PER_SCN times, no ROM data reads; captured on start
//  fill_byte  in   8       constant for fill mode; captured on start
//  busy       out  1       high from accepted start until done
//  done       out  1       1-cycle pulse after last bit's final sck falling edge + sce release
//  err        out  1       1-cycle pulse: start with scn_sel>=NUM_SCN (and fill_en=0); no transfer
//  mem_rd     out  1       ROM read strobe, 1 cycle
//  mem_addr   out  ADDR_W  ROM address
//  mem_data   in   8       ROM data, valid 1 cycle after mem_rd
//  lcd_sck    out  1       SPI clock, mode 0, idle low
//  lcd_mosi   out  1       SPI data, MSB first
//  lcd_dc     out  1       0=command, 1=data
//  lcd_sce    out  1       chip enable, active-low, low for the whole frame
//  lcd_rst_n  out  1       LCD reset, active-low
// BEHAVIOUR
//  Reset values: busy=0 done=0 err=0 mem_rd=0 mem_addr=0 lcd_sck=0 lcd_mosi=0 lcd_dc=0 lcd_sce=1 lcd_rst_n=0.
//  FSM: PWR_RST -> IDLE -> FETCH -> LATCH -> SHIFT -> NEXT -> (FETCH | FINISH) -> IDLE.
//  PWR_RST: lcd_rst_n=0 for RST_CYCLES clks after rst release, then 1; start ignored, busy=0.
//  IDLE: start accepted -> capture inputs, busy=1; bad scn_sel -> err pulse, stay IDLE, busy=0.
//  Byte sequence: if send_cfg, addr 0..CFG_BYTES-1 with dc=0; then BYTES_PER_SCN bytes with dc=1
//   from base = CFG_BYTES + scn_sel*BYTES_PER_SCN (multiply in ADDR_W bits, no truncation allowed).
//  FETCH: mem_rd=1 with mem_addr; LATCH: shift reg <= mem_data (or fill_byte; mem_rd stays 0 in fill).
//  SHIFT: sce=0, dc valid before first sck rise; 8 bits, each = CLK_DIV low + CLK_DIV high clks;
//   mosi changes only while sck low. Byte = 16*CLK_DIV clks + 2 clk fetch gap (sck low in gap).
//  NEXT: byte counter +1; last byte -> FINISH: sce=1 for one clk, then done pulse, busy=0.
//  Fill mode still honours send_cfg (preamble read from ROM).
//  start while busy or in PWR_RST: ignored, no queuing.
//  rst asserted mid-frame: all outputs to reset values immediately, PWR_RST re-runs.
//  Counters sized $clog2 of their max; byte counter never wraps within a frame.
// STRUCTURE
//  Shared package lcd_pkg: PCD8544 geometry constants (84, 48, 504), CFG_BYTES, state encoding.
//  Sub-module spi_byte_tx: load/busy/done, CLK_DIV divider, 8-bit MSB-first shifter, sck/mosi.
//  Top holds FSM, address/byte counters, base-address calc, power-up reset timer.
// TESTING (BYTES_PER_SCN=4, CFG_BYTES=2, NUM_SCN=3, CLK_DIV=2, ROM[a]=a)
//  Power-up: rst low then high -> lcd_rst_n low 16 clks, start during it ignored (busy stays 0).
//  start scn_sel=1 send_cfg=1 -> bytes 00,01 dc=0 then 06,07,08,09 dc=1; sce low throughout; 1 done.
//  start scn_sel=2 send_cfg=0 -> bytes 0A..0D dc=1, 34 sck-cycle-gap timing: 4*(32+2) clks busy.
//  fill_en=1 fill_byte=A5 send_cfg=0 -> four A5 bytes, mem_rd never asserted.
//  scn_sel=3 fill_en=0 -> err pulse 1 clk, sce stays 1, busy stays 0.
//  rst low during 3rd byte -> sce=1, sck=0, busy=0 next edge; new frame after PWR_RST correct.

Source files
------------

// File: rtl/lcd_scn_streamer_pkg.sv
// Shared definitions for the screen streamer: PCD8544 geometry, defaults and FSM encoding.
package lcd_scn_streamer_pkg;
   localparam int LCD_WIDTH     = 84;
   localparam int LCD_HEIGHT    = 48;
   localparam int LCD_BYTES     = LCD_WIDTH * LCD_HEIGHT / 8;
   localparam int CFG_BYTES_DEF = 5;
   localparam int SCN_SEL_W     = 4;

   typedef enum logic [2:0] {
      PWR_RST,
      IDLE,
      FETCH,
      LATCH,
      SHIFT,
      NEXT,
      FINISH
   } state_t;
endpackage

// File: rtl/lcd_scn_streamer_if.sv
// Control, ROM and LCD pin bundle between the host/ROM side (master) and the streamer (slave).
interface lcd_scn_streamer_if
   import lcd_scn_streamer_pkg::*;
#(
   parameter int ADDR_W = 13
) ();
   // start is a 1-cycle request honoured only while idle; busy spans the whole frame and
   // done pulses once after sce is released. No queuing: a start seen while busy is dropped.
   logic                 start;
   logic [SCN_SEL_W-1:0] scn_sel;
   logic                 send_cfg;
   logic                 fill_en;
   logic [7:0]           fill_byte;
   logic                 busy;
   logic                 done;
   logic                 err;
   logic                 mem_rd;
   logic [ADDR_W-1:0]    mem_addr;
   logic [7:0]           mem_data;
   logic                 lcd_sck;
   logic                 lcd_mosi;
   logic                 lcd_dc;
   logic                 lcd_sce;
   logic                 lcd_rst_n;

   modport master (
      output start, scn_sel, send_cfg, fill_en, fill_byte, mem_data,
      input  busy, done, err, mem_rd, mem_addr, lcd_sck, lcd_mosi, lcd_dc, lcd_sce, lcd_rst_n
   );

   modport slave (
      input  start, scn_sel, send_cfg, fill_en, fill_byte, mem_data,
      output busy, done, err, mem_rd, mem_addr, lcd_sck, lcd_mosi, lcd_dc, lcd_sce, lcd_rst_n
   );
endinterface

// File: rtl/lcd_scn_streamer_spi_byte_tx.sv
// Mode-0 SPI byte shifter: MSB first, each bit CLK_DIV clocks low then CLK_DIV clocks high.
module lcd_scn_streamer_spi_byte_tx #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] data,
   output logic       busy,
   output logic       done,
   output logic       sck,
   output logic       mosi
);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic             active_q;
   logic             phase_q;
   logic [DIV_W-1:0] div_q;
   logic [2:0]       bit_q;
   logic [7:0]       sh_q;
   logic             div_end;

   assign div_end = (div_q == DIV_W'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active_q <= 1'b0;
         phase_q  <= 1'b0;
         div_q    <= '0;
         bit_q    <= '0;
         sh_q     <= '0;
      end else if (load) begin
         active_q <= 1'b1;
         phase_q  <= 1'b0;
         div_q    <= '0;
         bit_q    <= '0;
         sh_q     <= data;
      end else if (active_q) begin
         if (div_end) begin
            div_q <= '0;
            if (!phase_q) begin
               phase_q <= 1'b1;
            end else begin
               // Shift only as sck falls, so mosi never moves while sck is high.
               phase_q <= 1'b0;
               if (bit_q == 3'd7) begin
                  active_q <= 1'b0;
               end else begin
                  bit_q <= bit_q + 3'd1;
                  sh_q  <= {sh_q[6:0], 1'b0};
               end
            end
         end else begin
            div_q <= div_q + DIV_W'(1);
         end
      end
   end

   // done fires one clock before the final high clock so the caller can overlap its
   // bookkeeping with the last sck-high cycle.
   assign done = active_q && (bit_q == 3'd7) &&
                 ((CLK_DIV == 1) ? !phase_q : (phase_q && div_q == DIV_W'(CLK_DIV - 2)));
   assign busy = active_q;
   assign sck  = phase_q;
   assign mosi = sh_q[7];
endmodule

// File: rtl/lcd_scn_streamer.sv
// Streams an optional config preamble plus one stored (or constant-fill) screen to a PCD8544 LCD.
module lcd_scn_streamer
   import lcd_scn_streamer_pkg::*;
#(
   parameter int NUM_SCN       = 16,
   parameter int BYTES_PER_SCN = LCD_BYTES,
   parameter int CFG_BYTES     = CFG_BYTES_DEF,
   parameter int ADDR_W        = 13,
   parameter int CLK_DIV       = 4,
   parameter int RST_CYCLES    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   lcd_scn_streamer_if.slave    bus,
   output state_t               fsm_state
);
   localparam int BC_MAX = (BYTES_PER_SCN > CFG_BYTES) ? BYTES_PER_SCN : CFG_BYTES;
   localparam int BC_W   = (BC_MAX > 1) ? $clog2(BC_MAX) : 1;
   localparam int RC_W   = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   state_t            state_q, state_d;
   logic [RC_W-1:0]   rst_cnt_q;
   logic [BC_W-1:0]   byte_cnt_q;
   logic [ADDR_W-1:0] addr_q, base_q;
   logic              cfg_q, fill_q;
   logic [7:0]        fill_byte_q;
   logic              done_q, err_q;
   logic              sel_ok, accept, reject, use_rom, cfg_last, data_last, in_frame;
   logic              tx_load, tx_busy, tx_done;

   function automatic logic [ADDR_W-1:0] scn_base(input logic [SCN_SEL_W-1:0] sel);
      return ADDR_W'(CFG_BYTES) + ADDR_W'(sel) * ADDR_W'(BYTES_PER_SCN);
   endfunction

   assign sel_ok    = {{(32-SCN_SEL_W){1'b0}}, bus.scn_sel} < 32'(NUM_SCN);
   assign accept    = (state_q == IDLE) && bus.start && (bus.fill_en || sel_ok);
   assign reject    = (state_q == IDLE) && bus.start && !bus.fill_en && !sel_ok;
   assign use_rom   = cfg_q || !fill_q;
   assign cfg_last  = cfg_q && (byte_cnt_q == BC_W'(CFG_BYTES - 1));
   assign data_last = !cfg_q && (byte_cnt_q == BC_W'(BYTES_PER_SCN - 1));

   always_comb begin
      state_d = state_q;
      tx_load = 1'b0;
      unique case (state_q)
         PWR_RST: if (rst_cnt_q == RC_W'(RST_CYCLES - 1)) state_d = IDLE;
         IDLE:    if (accept) state_d = FETCH;
         FETCH:   state_d = LATCH;
         LATCH: begin
            tx_load = 1'b1;
            state_d = SHIFT;
         end
         SHIFT:   if (tx_busy && tx_done) state_d = NEXT;
         NEXT:    state_d = data_last ? FINISH : FETCH;
         FINISH:  state_d = IDLE;
         default: state_d = PWR_RST;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= PWR_RST;
         rst_cnt_q   <= '0;
         byte_cnt_q  <= '0;
         addr_q      <= '0;
         base_q      <= '0;
         cfg_q       <= 1'b0;
         fill_q      <= 1'b0;
         fill_byte_q <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= (state_q == FINISH);
         err_q   <= reject;
         if (state_q == PWR_RST && state_d == PWR_RST) rst_cnt_q <= rst_cnt_q + RC_W'(1);
         if (accept) begin
            cfg_q       <= bus.send_cfg;
            fill_q      <= bus.fill_en;
            fill_byte_q <= bus.fill_byte;
            base_q      <= scn_base(bus.scn_sel);
            addr_q      <= bus.send_cfg ? '0 : scn_base(bus.scn_sel);
            byte_cnt_q  <= '0;
         end else if (state_q == NEXT) begin
            // Preamble ends by jumping to the screen base; the data counter restarts at 0.
            if (cfg_last) begin
               cfg_q      <= 1'b0;
               byte_cnt_q <= '0;
               addr_q     <= base_q;
            end else if (!data_last) begin
               byte_cnt_q <= byte_cnt_q + BC_W'(1);
               addr_q     <= addr_q + ADDR_W'(1);
            end
         end
      end
   end

   lcd_scn_streamer_spi_byte_tx #(.CLK_DIV(CLK_DIV)) u_tx (
      .clk  (clk),
      .rst  (rst),
      .load (tx_load),
      .data (use_rom ? bus.mem_data : fill_byte_q),
      .busy (tx_busy),
      .done (tx_done),
      .sck  (bus.lcd_sck),
      .mosi (bus.lcd_mosi)
   );

   assign in_frame      = (state_q == FETCH) || (state_q == LATCH) ||
                          (state_q == SHIFT) || (state_q == NEXT);
   assign bus.busy      = in_frame || (state_q == FINISH);
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.mem_rd    = (state_q == FETCH) && use_rom;
   assign bus.mem_addr  = addr_q;
   assign bus.lcd_dc    = in_frame && !cfg_q;
   assign bus.lcd_sce   = !in_frame;
   assign bus.lcd_rst_n = (state_q != PWR_RST);
   assign fsm_state     = state_q;
endmodule
